// File: rtl/writeback_if.sv
// writeback_if: result-path handshake between execution/load stages and the write-back block.
// Forwarding signals exist only when WRITEBACK_FWD_EN is defined.
interface writeback_if;
   logic        ex_valid_i;
   logic [3:0]  ex_r_i;
   logic [31:0] ex_data_i;
   logic        ld_valid_i;
   logic [3:0]  ld_r_i;
   logic [31:0] ld_data_i;
   logic        wb_o;
   logic [3:0]  wb_r_o;
   logic [31:0] wb_data_o;
   logic        stall_o;
   logic        overflow_o;
`ifdef WRITEBACK_FWD_EN
   logic [3:0]  fwd_r_i;
   logic        fwd_hit_o;
   logic [31:0] fwd_data_o;
   modport master (output ex_valid_i, ex_r_i, ex_data_i, ld_valid_i, ld_r_i, ld_data_i, fwd_r_i,
                   input wb_o, wb_r_o, wb_data_o, stall_o, overflow_o, fwd_hit_o, fwd_data_o);
   modport slave (input ex_valid_i, ex_r_i, ex_data_i, ld_valid_i, ld_r_i, ld_data_i, fwd_r_i,
                  output wb_o, wb_r_o, wb_data_o, stall_o, overflow_o, fwd_hit_o, fwd_data_o);
`else
   modport master (output ex_valid_i, ex_r_i, ex_data_i, ld_valid_i, ld_r_i, ld_data_i,
                   input wb_o, wb_r_o, wb_data_o, stall_o, overflow_o);
   modport slave (input ex_valid_i, ex_r_i, ex_data_i, ld_valid_i, ld_r_i, ld_data_i,
                  output wb_o, wb_r_o, wb_data_o, stall_o, overflow_o);
`endif
endinterface

// File: rtl/writeback.sv
// writeback: merges load and execution results into one register-file write port,
// deferring execution results in a FIFO; WRITEBACK_FWD_EN adds a forwarding lookup.
module writeback #(
   parameter int DEPTH = 4
) (
   input logic       clk,
   input logic       rst,
   writeback_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   logic [3:0]    mem_r [DEPTH];
   logic [31:0]   mem_d [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   cnt;
   logic          empty, full, pop, push, wr_en, sel;
   logic [3:0]    sel_r;
   logic [31:0]   sel_d;
   always_comb begin
      empty = cnt == '0;
      full  = cnt == (AW+1)'(DEPTH);
      pop   = !bus.ld_valid_i && !empty;
      push  = bus.ex_valid_i && (bus.ld_valid_i || !empty);
      wr_en = push && (!full || pop);
      sel   = bus.ld_valid_i || !empty || bus.ex_valid_i;
      sel_r = bus.ld_valid_i ? bus.ld_r_i : !empty ? mem_r[rd_ptr] : bus.ex_r_i;
      sel_d = bus.ld_valid_i ? bus.ld_data_i : !empty ? mem_d[rd_ptr] : bus.ex_data_i;
   end
   assign bus.stall_o = cnt >= (AW+1)'(DEPTH - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.wb_o       <= 1'b0;
         bus.wb_r_o     <= '0;
         bus.wb_data_o  <= '0;
         bus.overflow_o <= 1'b0;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         cnt            <= '0;
      end else begin
         bus.wb_o <= sel;
         if (sel) begin
            bus.wb_r_o    <= sel_r;
            bus.wb_data_o <= sel_d;
         end
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(pop);
         if (push && !wr_en) bus.overflow_o <= 1'b1;
      end
   end
   // storage needs no reset: occupancy alone defines which entries are live
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_r[wr_ptr] <= bus.ex_r_i;
         mem_d[wr_ptr] <= bus.ex_data_i;
      end
   end
`ifdef WRITEBACK_FWD_EN
   // scan oldest to youngest so the youngest FIFO match wins over the output register
   always_comb begin
      logic [AW-1:0] idx;
      idx = '0;
      bus.fwd_hit_o  = bus.wb_o && bus.wb_r_o == bus.fwd_r_i;
      bus.fwd_data_o = (bus.wb_o && bus.wb_r_o == bus.fwd_r_i) ? bus.wb_data_o : '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if ((AW+1)'(i) < cnt && mem_r[idx] == bus.fwd_r_i) begin
            bus.fwd_hit_o  = 1'b1;
            bus.fwd_data_o = mem_d[idx];
         end
      end
   end
`endif
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed vectors for writeback with hand-computed expectations.
module tb_writeback;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   writeback_if bus ();
   writeback #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.ex_valid_i = 1'b0;
      bus.ld_valid_i = 1'b0;
   endtask
   task automatic drive(input logic ld, input logic [3:0] lr, input logic [31:0] ldat,
                        input logic ex, input logic [3:0] er, input logic [31:0] edat);
      bus.ld_valid_i = ld;
      bus.ld_r_i     = lr;
      bus.ld_data_i  = ldat;
      bus.ex_valid_i = ex;
      bus.ex_r_i     = er;
      bus.ex_data_i  = edat;
   endtask
   task automatic check_wb(input string tag, input logic [3:0] r, input logic [31:0] d);
      check({tag, ".wb"}, 32'(bus.wb_o), 32'd1);
      check({tag, ".r"}, 32'(bus.wb_r_o), 32'(r));
      check({tag, ".data"}, bus.wb_data_o, d);
   endtask
   initial begin
      int nxt;
      drive(0, 0, 0, 0, 0, 0);
`ifdef WRITEBACK_FWD_EN
      bus.fwd_r_i = '0;
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst.wb", 32'(bus.wb_o), 0);
      check("rst.r", 32'(bus.wb_r_o), 0);
      check("rst.data", bus.wb_data_o, 0);
      check("rst.ovf", 32'(bus.overflow_o), 0);
      check("rst.stall", 32'(bus.stall_o), 0);
      // lone execution result goes straight through
      drive(0, 0, 0, 1, 3, 32'h1234);
      step();
      idle();
      check_wb("ex_only", 3, 32'h1234);
      step();
      check("ex_only.empty", 32'(bus.wb_o), 0);
      check("ex_only.hold_r", 32'(bus.wb_r_o), 3);
      check("ex_only.hold_d", bus.wb_data_o, 32'h1234);
      // load wins, execution result deferred one cycle
      drive(1, 5, 32'hAAAA, 1, 6, 32'hBBBB);
      step();
      idle();
      check_wb("pair.ld", 5, 32'hAAAA);
      step();
      check_wb("pair.ex", 6, 32'hBBBB);
      step();
      check("pair.done", 32'(bus.wb_o), 0);
      // fill to full, then overflow on fifth pair
      for (int i = 0; i < 4; i++) begin
         drive(1, 4'(i), 32'h100 + 32'(i), 1, 4'(8 + i), 32'h200 + 32'(i));
         step();
         check_wb($sformatf("fill%0d", i), 4'(i), 32'h100 + 32'(i));
         check($sformatf("fill%0d.stall", i), 32'(bus.stall_o), (i >= 2) ? 32'd1 : 32'd0);
      end
      check("fill.ovf", 32'(bus.overflow_o), 0);
      drive(1, 4, 32'h104, 1, 12, 32'h204);
      step();
      idle();
      check_wb("ovf.ld", 4, 32'h104);
      check("ovf.flag", 32'(bus.overflow_o), 1);
      check("ovf.stall", 32'(bus.stall_o), 1);
      for (int i = 0; i < 4; i++) begin
         step();
         check_wb($sformatf("drain%0d", i), 4'(8 + i), 32'h200 + 32'(i));
         check($sformatf("drain%0d.stall", i), 32'(bus.stall_o), (i == 0) ? 32'd1 : 32'd0);
      end
      step();
      check("drain.dropped", 32'(bus.wb_o), 0);
      check("drain.sticky", 32'(bus.overflow_o), 1);
      // reset with two queued entries and a same-cycle valid input
      drive(1, 1, 32'h11, 1, 2, 32'h22);
      step();
      drive(1, 3, 32'h33, 1, 4, 32'h44);
      step();
      drive(0, 0, 0, 1, 9, 32'h99);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      check("mid_rst.wb", 32'(bus.wb_o), 0);
      check("mid_rst.r", 32'(bus.wb_r_o), 0);
      check("mid_rst.data", bus.wb_data_o, 0);
      check("mid_rst.ovf", 32'(bus.overflow_o), 0);
      check("mid_rst.stall", 32'(bus.stall_o), 0);
      step();
      check("mid_rst.q1", 32'(bus.wb_o), 0);
      step();
      check("mid_rst.q2", 32'(bus.wb_o), 0);
      // ten execution results with a load every third cycle: wraps pointers, never overflows
      nxt = 0;
      for (int k = 0; k < 10; k++) begin
         drive(k % 3 == 0, 4'hF, 32'hF00 + 32'(k), 1, 4'(k), 32'h300 + 32'(k));
         step();
         if (k % 3 == 0) check_wb($sformatf("wrap%0d.ld", k), 4'hF, 32'hF00 + 32'(k));
         else begin
            check_wb($sformatf("wrap%0d.ex", k), 4'(nxt), 32'h300 + 32'(nxt));
            nxt++;
         end
      end
      idle();
      check("wrap.stall", 32'(bus.stall_o), 1);
      while (nxt < 10) begin
         step();
         check_wb($sformatf("wrap.drain%0d", nxt), 4'(nxt), 32'h300 + 32'(nxt));
         nxt++;
      end
      step();
      check("wrap.done", 32'(bus.wb_o), 0);
      check("wrap.ovf", 32'(bus.overflow_o), 0);
`ifdef WRITEBACK_FWD_EN
      drive(1, 1, 32'h55, 1, 7, 32'h1);
      step();
      drive(1, 1, 32'h66, 1, 7, 32'h2);
      step();
      idle();
      bus.fwd_r_i = 4'd7;
      #1;
      check("fwd.hit7", 32'(bus.fwd_hit_o), 1);
      check("fwd.data7", bus.fwd_data_o, 32'h2);
      bus.fwd_r_i = 4'd9;
      #1;
      check("fwd.hit9", 32'(bus.fwd_hit_o), 0);
      check("fwd.data9", bus.fwd_data_o, 0);
      bus.fwd_r_i = 4'd1;
      #1;
      check("fwd.hit1", 32'(bus.fwd_hit_o), 1);
      check("fwd.data1", bus.fwd_data_o, 32'h66);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter DEPTH, default 4, entry count of the deferred-result FIFO; power of two, >=2.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 ex_valid_i  in  1  execution-path result valid this cycle.
REQ-005 ex_r_i  in  4  execution-path target register address.
REQ-006 ex_data_i  in  32  execution-path result data.
REQ-007 ld_valid_i  in  1  load-path result valid this cycle.
REQ-008 ld_r_i  in  4  load-path target register address.
REQ-009 ld_data_i  in  32  load-path result data.
REQ-010 wb_o  out  1  write-back enable to the register file (1: write).
REQ-011 wb_r_o  out  4  write-back target register address.
REQ-012 wb_data_o  out  32  write-back data.
REQ-013 stall_o  out  1  upstream stall request (1: hold execution path).
REQ-014 overflow_o  out  1  sticky flag, execution result dropped on full FIFO.

Function
REQ-015 Output priority each cycle: ld_valid_i first, then FIFO head, then ex_valid_i direct; wb_o/wb_r_o/wb_data_o registered, latency exactly 1 cycle from the selected input.
REQ-016 ex_valid_i with ld_valid_i high or FIFO non-empty shall push {ex_r_i, ex_data_i} into the FIFO instead of writing directly.
REQ-017 FIFO head shall pop only in a cycle with ld_valid_i low; execution results leave in arrival order.
REQ-018 Simultaneous push and pop shall leave occupancy unchanged, permitted even when full.
REQ-019 Push while full with no pop shall drop the entry and set overflow_o; occupancy and contents unchanged.
REQ-020 Ordering between load and execution results is not preserved; same-register conflicts are excluded by the decode-stage reservation.
REQ-021 stall_o shall be combinational from registered occupancy: 1 when occupancy >= DEPTH-1, else 0.
REQ-022 When no source is selected, wb_o shall be 0 and wb_r_o/wb_data_o hold their previous values.
REQ-023 Register address 0 shall be written like any other address; filtering is the register file's concern.
REQ-024 Read/write pointers shall be log2(DEPTH) bits wrapping modulo DEPTH; occupancy counter log2(DEPTH)+1 bits.

Reset
REQ-025 With rst high at a clock edge: wb_o=0, wb_r_o=0, wb_data_o=0, overflow_o=0, pointers and occupancy 0, stall_o=0 the following cycle.
REQ-026 Reset mid-operation shall discard all FIFO entries and ignore same-cycle valid inputs.
REQ-027 overflow_o shall clear only by reset.

Configuration
REQ-028 Macro WRITEBACK_FWD_EN defined: add ports fwd_r_i (in, 4), fwd_hit_o (out, 1), fwd_data_o (out, 32).
REQ-029 With WRITEBACK_FWD_EN: fwd_hit_o=1 and fwd_data_o=youngest matching data when fwd_r_i matches a valid FIFO entry or the output register with wb_o=1; FIFO youngest beats output register; combinational; else fwd_hit_o=0, fwd_data_o=0.
REQ-030 Without WRITEBACK_FWD_EN: ports absent, no forwarding logic, all other behaviour identical.

Verification
REQ-031 ex_valid_i=1, ex_r_i=3, ex_data_i=0x1234 alone -> next cycle wb_o=1, wb_r_o=3, wb_data_o=0x1234; FIFO empty.
REQ-032 ld(r=5,0xAAAA) and ex(r=6,0xBBBB) same cycle -> cycle+1 writes r5 0xAAAA, cycle+2 writes r6 0xBBBB.
REQ-033 Four consecutive ld+ex pairs, DEPTH=4 -> stall_o=1 once occupancy reaches 3; fifth ex push with ld high sets overflow_o=1, FIFO contents unchanged.
REQ-034 FIFO holding 2 entries, rst pulsed 1 cycle -> wb_o=0, occupancy 0, stall_o=0; queued entries never written.
REQ-035 Wrap-around: push/pop 10 ex results through DEPTH=4 with ld interleaving -> all 10 written in order, no overflow.
REQ-036 WRITEBACK_FWD_EN, FIFO holds r7=0x1 then r7=0x2, fwd_r_i=7 -> fwd_hit_o=1, fwd_data_o=0x2; fwd_r_i=9 -> fwd_hit_o=0.
